// File: rtl/bel_avl_pkg.sv
// bel_avl_pkg: shared types and constants for the Avalon block master.
//   DWIDTH        data width taken from the FFT subsystem definition
//   MAX_OUTST_*   legal range of outstanding Avalon reads
//   OUTST_CW      width of the outstanding-read counter (holds 0..MAX_OUTST_MAX)
//   bel_avl_state_e  master FSM state encoding
`include "bel_fft_def.v"

package bel_avl_pkg;

  localparam int unsigned DWIDTH        = `BEL_FFT_DWIDTH;
  localparam int unsigned MAX_OUTST_MIN = 1;
  localparam int unsigned MAX_OUTST_MAX = 8;
  localparam int unsigned OUTST_CW      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LD_RUN,
    ST_FETCH,
    ST_ISSUE,
    FIN
  } bel_avl_state_e;

  // Force an outstanding-read limit into the supported range.
  function automatic int unsigned clamp_outst(input int unsigned n);
    if (n < MAX_OUTST_MIN) return MAX_OUTST_MIN;
    if (n > MAX_OUTST_MAX) return MAX_OUTST_MAX;
    return n;
  endfunction

endpackage

// File: rtl/bel_avl_blk_mst_if.sv
// bel_avl_blk_mst_if: Avalon-MM master/slave signal bundle.
//   address, read, write, writedata       master -> slave command
//   readdata, readdatavalid, waitrequest  slave -> master response
interface bel_avl_blk_mst_if #(
  parameter int unsigned ADR_WIDTH = 6
);

  logic [ADR_WIDTH-1:0]           address;
  logic                           read;
  logic                           write;
  logic [bel_avl_pkg::DWIDTH-1:0] writedata;
  logic [bel_avl_pkg::DWIDTH-1:0] readdata;
  logic                           readdatavalid;
  logic                           waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/bel_avl_outst_cnt.sv
// bel_avl_outst_cnt: saturating up/down counter of outstanding Avalon reads.
//   clk_i, rst_i  clock, synchronous active-low reset
//   inc           a read was accepted this cycle
//   dec           a read response arrived this cycle (ignored when count is 0)
//   cnt_o         current count
//   full_o        count after this cycle's update equals MAX
module bel_avl_outst_cnt
  import bel_avl_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc,
  input  logic                dec,
  output logic [OUTST_CW-1:0] cnt_o,
  output logic                full_o
);

  localparam logic [OUTST_CW-1:0] MAX_C = OUTST_CW'(MAX);

  logic [OUTST_CW-1:0] cnt_q;
  logic [OUTST_CW-1:0] cnt_d;
  logic                dec_ok;
  logic                inc_ok;

  always_comb begin
    dec_ok = dec && (cnt_q != '0);
    // An increment at the limit is still legal when a decrement frees a slot.
    inc_ok = inc && ((cnt_q != MAX_C) || dec_ok);
    cnt_d  = cnt_q;
    if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + OUTST_CW'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - OUTST_CW'(1);
    end
    // Look-ahead so the caller can register its next read request.
    full_o = (cnt_d == MAX_C);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bel_fft_def.v
// Shared data-path width definition for the BEL FFT subsystem.
`ifndef BEL_FFT_DEF_V
`define BEL_FFT_DEF_V
`define BEL_FFT_DWIDTH 32
`endif

// File: rtl/bel_avl_blk_mst.sv
// bel_avl_blk_mst: block-move master between an Avalon-MM slave and a local
// single-port buffer.
//   clk_i, rst_i         clock, synchronous active-low reset
//   start, dir           command strobe; 0 = Avalon->buffer, 1 = buffer->Avalon
//   base_adr, len        first Avalon word address, number of words
//   busy, done           command in progress, one-cycle completion pulse
//   avl                  Avalon-MM master port
//   lb_adr, lb_we,       local-buffer shared address and write port
//   lb_wdata, lb_rdata   (lb_rdata valid one cycle after lb_adr)
// LEN_WIDTH must be at least ADR_WIDTH.
module bel_avl_blk_mst
  import bel_avl_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 6,
  parameter int unsigned LEN_WIDTH = 7,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADR_WIDTH-1:0]  base_adr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  bel_avl_blk_mst_if.master     avl,
  output logic [ADR_WIDTH-1:0]  lb_adr,
  output logic                  lb_we,
  output logic [DWIDTH-1:0]     lb_wdata,
  input  logic [DWIDTH-1:0]     lb_rdata
);

  localparam int unsigned OUTST_LIM = clamp_outst(MAX_OUTST);

  bel_avl_state_e       state_q,    state_d;
  logic [ADR_WIDTH-1:0] base_q,     base_d;
  logic [LEN_WIDTH-1:0] len_q,      len_d;
  logic [LEN_WIDTH-1:0] issued_q,   issued_d;
  logic [LEN_WIDTH-1:0] received_q, received_d;
  logic [LEN_WIDTH-1:0] sent_q,     sent_d;
  logic                 read_q,     read_d;
  logic                 write_q,    write_d;
  logic [ADR_WIDTH-1:0] address_q,  address_d;
  logic [ADR_WIDTH-1:0] lb_adr_q,   lb_adr_d;
  logic                 lb_we_q,    lb_we_d;
  logic [DWIDTH-1:0]    lb_wdata_q, lb_wdata_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  logic                 rd_acc;
  logic                 wr_acc;
  logic                 rdv_ok;
  logic [OUTST_CW-1:0]  outst_cnt;
  logic                 outst_full;

  assign rd_acc = read_q  && !avl.waitrequest;
  assign wr_acc = write_q && !avl.waitrequest;
  // Responses with nothing outstanding (stale reads from before a reset) are dropped.
  assign rdv_ok = avl.readdatavalid && (outst_cnt != '0);

  bel_avl_outst_cnt #(
    .MAX (OUTST_LIM)
  ) u_outst (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc    (rd_acc),
    .dec    (avl.readdatavalid),
    .cnt_o  (outst_cnt),
    .full_o (outst_full)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    sent_d     = sent_q;
    read_d     = 1'b0;
    write_d    = 1'b0;
    address_d  = address_q;
    lb_adr_d   = lb_adr_q;
    lb_we_d    = 1'b0;
    lb_wdata_d = lb_wdata_q;

    if (rdv_ok) begin
      lb_we_d    = 1'b1;
      lb_wdata_d = avl.readdata;
      lb_adr_d   = received_q[ADR_WIDTH-1:0];
      received_d = received_q + LEN_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_adr;
          len_d      = len;
          issued_d   = '0;
          received_d = '0;
          sent_d     = '0;
          if (len == '0) begin
            state_d = FIN;
          end else if (dir) begin
            state_d  = ST_FETCH;
            lb_adr_d = '0;
          end else begin
            // First read goes out on the first LD_RUN cycle.
            state_d   = LD_RUN;
            read_d    = 1'b1;
            address_d = base_adr;
          end
        end
      end
      LD_RUN: begin
        issued_d = issued_q + LEN_WIDTH'(rd_acc);
        if (received_q == len_q) begin
          state_d = FIN;
        end else begin
          // Under waitrequest issued_d and the count do not grow, so read and
          // address naturally stay put.
          read_d    = (issued_d < len_q) && !outst_full;
          address_d = base_q + issued_d[ADR_WIDTH-1:0];
        end
      end
      ST_FETCH: begin
        state_d   = ST_ISSUE;
        write_d   = 1'b1;
        address_d = base_q + sent_q[ADR_WIDTH-1:0];
      end
      ST_ISSUE: begin
        if (wr_acc) begin
          sent_d = sent_q + LEN_WIDTH'(1);
          if (sent_d == len_q) begin
            state_d = FIN;
          end else begin
            state_d  = ST_FETCH;
            lb_adr_d = sent_d[ADR_WIDTH-1:0];
          end
        end else begin
          write_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      sent_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      address_q  <= '0;
      lb_adr_q   <= '0;
      lb_we_q    <= 1'b0;
      lb_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      sent_q     <= sent_d;
      read_q     <= read_d;
      write_q    <= write_d;
      address_q  <= address_d;
      lb_adr_q   <= lb_adr_d;
      lb_we_q    <= lb_we_d;
      lb_wdata_q <= lb_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign avl.address = address_q;
  assign avl.read    = read_q;
  assign avl.write   = write_q;
  // lb_rdata is the buffer's registered output and lb_adr is held through
  // ST_ISSUE, so it is stable for the whole write.
  assign avl.writedata = write_q ? lb_rdata : '0;

  assign busy     = busy_q;
  assign done     = done_q;
  assign lb_adr   = lb_adr_q;
  assign lb_we    = lb_we_q;
  assign lb_wdata = lb_wdata_q;

endmodule
